out_data_mux: RTL and testbench
===============================

# out_data_mux

Transmit-side lane mapper, the counterpart of the input lane mux. It takes 9 internal channel bits per clk320 cycle and routes any channel to any output lane through a per-lane select. Each lane has an optional extra retiming stage. Configuration is double-buffered and applied only on a frame boundary, and a built-in training-pattern mode supports link alignment with the far-end receiver.

## Interface
Parameters:
- N_LANES, 9, number of channels and output lanes.
- SEL_W, 8, width of each per-lane select field.
- TRAIN_PAT, 8'hA5, 8-bit training pattern.

Ports:
- clk320  in  1  sole clock.
- rst  in  1  asynchronous, active-low reset.
- d_in  in  N_LANES  channel data, one bit per channel per cycle.
- OutSetting  in  N_LANES*SEL_W  requested select per lane; lane i uses bits [i*SEL_W +: SEL_W].
- EdgeSel  in  N_LANES  requested retime enable per lane.
- cfg_load  in  1  one-cycle strobe that captures OutSetting and EdgeSel into the shadow register.
- frame_sync  in  1  one-cycle frame-boundary strobe; the shadow configuration becomes active here.
- train_en  in  1  replaces data on all lanes with the training pattern.
- s_out  out  N_LANES  lane outputs, registered.
- cfg_busy  out  1  high while a shadow configuration is pending.
- cfg_done  out  1  one-cycle pulse after the shadow configuration becomes active.

## Operation
- Config FSM has two states, IDLE and PENDING.
  - IDLE with cfg_load: OutSetting and EdgeSel go to the shadow register; next state PENDING. A frame_sync in the same cycle is ignored.
  - PENDING with cfg_load only: the shadow register is overwritten (last write wins); state stays PENDING.
  - PENDING with frame_sync only: active config gets the shadow contents; next state IDLE; cfg_done pulses in the following cycle.
  - PENDING with cfg_load and frame_sync together: active config gets the current OutSetting/EdgeSel inputs directly; next state IDLE; cfg_done pulses.
  - IDLE with frame_sync only: no effect.
- cfg_busy = (state == PENDING).
- Mux, per lane i: if active sel[i] < N_LANES, m[i] = d_in[sel[i]]; otherwise m[i] = 0. The full SEL_W bits are compared, so values 9..255 give 0.
- Training mode:
  - 3-bit counter cnt increments every cycle while train_en = 1.
  - cnt is held at 0 while train_en = 0.
  - While training, m[i] = TRAIN_PAT[(cnt + i) mod 8].
- Pipeline:
  - stage1[i] <= m[i].
  - stage2[i] <= stage1[i].
  - s_out[i] <= active EdgeSel[i] ? stage2[i] : stage1[i].
- Reset values (asserted asynchronously, released synchronously to clk320):
  - state = IDLE; cfg_busy = 0; cfg_done = 0; cnt = 0.
  - active sel[i] = i (identity map); active EdgeSel = 0.
  - Shadow register, stage1, stage2 and s_out all 0.

## Timing
- Latency d_in to s_out is 2 cycles with EdgeSel[i] = 0 and 3 cycles with EdgeSel[i] = 1.
- The new mapping takes effect on the cycle after frame_sync. s_out shows the new mapping from 2 or 3 cycles after that, depending on the lane's new EdgeSel. Lane bits already in the pipeline are not flushed.
- Changing EdgeSel[i] from 0 to 1 repeats one bit on lane i. Changing it from 1 to 0 drops one bit. Both are accepted.
- The first training bit appears on s_out 2 or 3 cycles after train_en rises, starting from cnt = 0 (lane 0 sends TRAIN_PAT[0] first).
- cfg_done asserts exactly 1 cycle after the applying frame_sync and lasts exactly 1 cycle.
- A reset in PENDING discards the shadow configuration and restores the identity map.

## Structure
- Package out_mux_pkg holds N_LANES, SEL_W, TRAIN_PAT and the config-state enum (IDLE, PENDING).
- Sub-module out_lane_retime is instantiated once per lane and contains stage1, stage2 and the EdgeSel output select.
- The top level contains the config FSM, the shadow and active registers, the mux and the training counter.

## Test plan
- Reset then d_in = 9'h0F5: s_out = 9'h0F5 two cycles later (identity map); cfg_busy = 0.
- cfg_load with lane0 sel = 8, other lanes unchanged, then frame_sync 5 cycles later:
  - cfg_busy is high for 5 cycles; cfg_done pulses once.
  - s_out[0] follows d_in[8] from 3 cycles after frame_sync.
- Lane 3 sel = 9 and sel = 255: s_out[3] = 0 for all d_in.
- Two cfg_load strobes before frame_sync: only the second configuration becomes active.
- cfg_load and frame_sync asserted together:
  - From IDLE: enters PENDING and applies nothing.
  - From PENDING: the inputs apply immediately and cfg_done pulses.
- EdgeSel = 9'h1FF with train_en = 1:
  - lane i shows TRAIN_PAT[(k + i) mod 8] at cycle 3 + k after train_en rises.
  - Asserting rst mid-sequence gives s_out = 0 and the identity map at once.

Source files
------------

// File: rtl/out_data_mux_pkg.sv
// Shared constants, config-state type and helpers for the transmit-side lane mapper.
package out_mux_pkg;

  localparam int unsigned N_LANES   = 9;
  localparam int unsigned SEL_W     = 8;
  localparam logic [7:0]  TRAIN_PAT = 8'hA5;
  localparam int unsigned CFG_W     = N_LANES * SEL_W;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } cfg_state_t;

  function automatic logic [CFG_W-1:0] identity_sel();
    logic [CFG_W-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < N_LANES; i++) begin
      v[i*SEL_W +: SEL_W] = SEL_W'(i);
    end
    return v;
  endfunction

  // Training bit index for a lane: rotates the pattern by lane number.
  function automatic logic [2:0] train_idx(input logic [2:0] cnt, input int unsigned lane);
    return 3'(cnt + 3'(lane));
  endfunction

endpackage

// File: rtl/out_data_mux_if.sv
// Data, configuration and status bundle of the lane mapper.
interface out_data_mux_if;
  import out_mux_pkg::*;

  logic [N_LANES-1:0] d_in;
  logic [CFG_W-1:0]   OutSetting;
  logic [N_LANES-1:0] EdgeSel;
  logic               cfg_load;
  logic               frame_sync;
  logic               train_en;
  logic [N_LANES-1:0] s_out;
  logic               cfg_busy;
  logic               cfg_done;

  modport master (
    output d_in, OutSetting, EdgeSel, cfg_load, frame_sync, train_en,
    input  s_out, cfg_busy, cfg_done
  );

  modport slave (
    input  d_in, OutSetting, EdgeSel, cfg_load, frame_sync, train_en,
    output s_out, cfg_busy, cfg_done
  );

endinterface

// File: rtl/out_data_mux_lane_retime.sv
// One output lane: two-stage pipeline with optional extra retiming stage.
module out_lane_retime (
  input  logic clk320,
  input  logic rst,
  input  logic i_m,
  input  logic i_edge_sel,
  output logic o_s_out
);

  logic r_stage1;
  logic r_stage2;
  logic r_s_out;

  always_ff @(posedge clk320 or negedge rst) begin
    if (!rst) begin
      r_stage1 <= 1'b0;
      r_stage2 <= 1'b0;
      r_s_out  <= 1'b0;
    end else begin
      r_stage1 <= i_m;
      r_stage2 <= r_stage1;
      r_s_out  <= i_edge_sel ? r_stage2 : r_stage1;
    end
  end

  assign o_s_out = r_s_out;

endmodule

// File: rtl/out_data_mux.sv
// Transmit lane mapper: double-buffered per-lane select applied on frame_sync,
// training-pattern override, per-lane retiming.
module out_data_mux
  import out_mux_pkg::*;
(
  input  logic          clk320,
  input  logic          rst,
  out_data_mux_if.slave bus
);

  cfg_state_t         r_state;
  logic               r_cfg_busy;
  logic               r_cfg_done;
  logic [CFG_W-1:0]   r_shadow_sel;
  logic [N_LANES-1:0] r_shadow_edge;
  logic [CFG_W-1:0]   r_act_sel;
  logic [N_LANES-1:0] r_act_edge;
  logic [2:0]         r_cnt;
  logic [N_LANES-1:0] w_m;
  logic [N_LANES-1:0] w_s_out;

  always_ff @(posedge clk320 or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_cfg_busy    <= 1'b0;
      r_cfg_done    <= 1'b0;
      r_shadow_sel  <= '0;
      r_shadow_edge <= '0;
      r_act_sel     <= identity_sel();
      r_act_edge    <= '0;
    end else begin
      r_cfg_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.cfg_load) begin
            r_shadow_sel  <= bus.OutSetting;
            r_shadow_edge <= bus.EdgeSel;
            r_state       <= PENDING;
            r_cfg_busy    <= 1'b1;
          end
        end
        PENDING: begin
          if (bus.frame_sync) begin
            // A simultaneous load bypasses the shadow and applies directly.
            r_act_sel  <= bus.cfg_load ? bus.OutSetting : r_shadow_sel;
            r_act_edge <= bus.cfg_load ? bus.EdgeSel    : r_shadow_edge;
            r_state    <= IDLE;
            r_cfg_busy <= 1'b0;
            r_cfg_done <= 1'b1;
          end else if (bus.cfg_load) begin
            r_shadow_sel  <= bus.OutSetting;
            r_shadow_edge <= bus.EdgeSel;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_cfg_busy <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk320 or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (!bus.train_en) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 3'd1;
    end
  end

  always_comb begin : mux
    logic [SEL_W-1:0] w_sel;
    w_sel = '0;
    w_m   = '0;
    for (int unsigned i = 0; i < N_LANES; i++) begin
      w_sel = r_act_sel[i*SEL_W +: SEL_W];
      if (bus.train_en) begin
        w_m[i] = TRAIN_PAT[train_idx(r_cnt, i)];
      end else if (w_sel < SEL_W'(N_LANES)) begin
        w_m[i] = bus.d_in[w_sel[3:0]];
      end
    end
  end

  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    out_lane_retime u_retime (
      .clk320     (clk320),
      .rst        (rst),
      .i_m        (w_m[g]),
      .i_edge_sel (r_act_edge[g]),
      .o_s_out    (w_s_out[g])
    );
  end

  assign bus.s_out    = w_s_out;
  assign bus.cfg_busy = r_cfg_busy;
  assign bus.cfg_done = r_cfg_done;

endmodule

// File: tb/tb_out_data_mux.sv
// Bench for out_data_mux: cycle-level reference model plus directed vectors.
module tb_out_data_mux;

  logic clk;
  logic rst;
  out_data_mux_if bus();

  out_data_mux dut (
    .clk320 (clk),
    .rst    (rst),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: value history per lane, config as plain arrays.
  logic [7:0] pat = 8'hA5;
  int         act_sel[9];
  int         sh_sel[9];
  bit         act_edge[9];
  bit         sh_edge[9];
  bit         pending;
  int         run;
  logic [8:0] m_now, m1, m2;
  logic [8:0] exp_s_out;
  bit         exp_busy, exp_done;

  task automatic model_reset();
    for (int i = 0; i < 9; i++) begin
      act_sel[i] = i; sh_sel[i] = 0; act_edge[i] = 0; sh_edge[i] = 0;
    end
    pending = 0; run = 0; m_now = '0; m1 = '0; m2 = '0;
    exp_s_out = '0; exp_busy = 0; exp_done = 0;
  endtask

  initial model_reset();

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < 9; i++) begin
        if (bus.train_en)          m_now[i] = pat[(run + i) % 8];
        else if (act_sel[i] < 9)   m_now[i] = bus.d_in[act_sel[i]];
        else                       m_now[i] = 1'b0;
        exp_s_out[i] = act_edge[i] ? m2[i] : m1[i];
      end
      m2 = m1;
      m1 = m_now;
      exp_done = 0;
      if (!pending) begin
        if (bus.cfg_load) begin
          for (int i = 0; i < 9; i++) begin
            sh_sel[i] = int'(bus.OutSetting[i*8 +: 8]); sh_edge[i] = bus.EdgeSel[i];
          end
          pending = 1;
        end
      end else if (bus.frame_sync) begin
        for (int i = 0; i < 9; i++) begin
          act_sel[i]  = bus.cfg_load ? int'(bus.OutSetting[i*8 +: 8]) : sh_sel[i];
          act_edge[i] = bus.cfg_load ? bus.EdgeSel[i] : sh_edge[i];
        end
        pending = 0;
        exp_done = 1;
      end else if (bus.cfg_load) begin
        for (int i = 0; i < 9; i++) begin
          sh_sel[i] = int'(bus.OutSetting[i*8 +: 8]); sh_edge[i] = bus.EdgeSel[i];
        end
      end
      exp_busy = pending;
      run = bus.train_en ? run + 1 : 0;
    end
  end

  always @(negedge clk) begin
    check("model_s_out", 32'(bus.s_out), 32'(exp_s_out));
    check("model_busy", 32'(bus.cfg_busy), 32'(exp_busy));
    check("model_done", 32'(bus.cfg_done), 32'(exp_done));
  end

  // Stimulus helpers
  int cfg[9];

  function automatic logic [71:0] pack_cfg();
    logic [71:0] v;
    for (int i = 0; i < 9; i++) v[i*8 +: 8] = 8'(cfg[i]);
    return v;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [8:0] edge_v);
    bus.OutSetting = pack_cfg();
    bus.EdgeSel    = edge_v;
    bus.cfg_load   = 1'b1;
    step(1);
    bus.cfg_load   = 1'b0;
    bus.frame_sync = 1'b1;
    step(1);
    bus.frame_sync = 1'b0;
  endtask

  logic [8:0] vec_in[4]  = '{9'h0FF, 9'h100, 9'h0AA, 9'h155};
  logic [8:0] vec_exp[4] = '{9'h0FE, 9'h101, 9'h0AA, 9'h155};
  int n_busy;

  initial begin
    rst = 1'b0;
    bus.d_in = '0; bus.OutSetting = '0; bus.EdgeSel = '0;
    bus.cfg_load = 1'b0; bus.frame_sync = 1'b0; bus.train_en = 1'b0;
    for (int i = 0; i < 9; i++) cfg[i] = i;

    step(1);
    check("reset_s_out", 32'(bus.s_out), 32'h0);
    check("reset_busy", 32'(bus.cfg_busy), 32'h0);
    check("reset_done", 32'(bus.cfg_done), 32'h0);
    step(1);
    rst = 1'b1;

    bus.d_in = 9'h0F5;
    step(2);
    check("identity_map", 32'(bus.s_out), 32'h0F5);
    check("identity_busy", 32'(bus.cfg_busy), 32'h0);

    // Lane 0 remapped to channel 8, applied five cycles after the load.
    bus.d_in = 9'h100;
    cfg[0] = 8;
    bus.OutSetting = pack_cfg();
    bus.cfg_load = 1'b1;
    step(1);
    bus.cfg_load = 1'b0;
    n_busy = 0;
    for (int k = 0; k < 5; k++) begin
      if (bus.cfg_busy) n_busy++;
      if (k == 4) bus.frame_sync = 1'b1;
      step(1);
    end
    bus.frame_sync = 1'b0;
    check("busy_cycles", 32'(n_busy), 32'd5);
    check("busy_cleared", 32'(bus.cfg_busy), 32'h0);
    check("done_pulse", 32'(bus.cfg_done), 32'h1);
    step(1);
    check("done_one_cycle", 32'(bus.cfg_done), 32'h0);
    step(1);
    check("lane0_from_d8", 32'(bus.s_out), 32'h101);
    for (int v = 0; v < 4; v++) begin
      bus.d_in = vec_in[v];
      step(2);
      check("lane0_vec", 32'(bus.s_out), 32'(vec_exp[v]));
    end

    // Load and frame_sync together: from IDLE only loads, from PENDING applies inputs.
    cfg[0] = 0; cfg[3] = 5;
    bus.OutSetting = pack_cfg();
    bus.cfg_load = 1'b1; bus.frame_sync = 1'b1;
    step(1);
    check("both_idle_busy", 32'(bus.cfg_busy), 32'h1);
    check("both_idle_done", 32'(bus.cfg_done), 32'h0);
    cfg[3] = 9;
    bus.OutSetting = pack_cfg();
    step(1);
    bus.cfg_load = 1'b0; bus.frame_sync = 1'b0;
    check("both_pend_busy", 32'(bus.cfg_busy), 32'h0);
    check("both_pend_done", 32'(bus.cfg_done), 32'h1);
    bus.d_in = 9'h1FF;
    step(2);
    check("sel9_all_ones", 32'(bus.s_out), 32'h1F7);
    bus.d_in = 9'h008;
    step(2);
    check("sel9_bit3", 32'(bus.s_out), 32'h000);

    cfg[3] = 255;
    apply(9'h000);
    bus.d_in = 9'h1FF;
    step(2);
    check("sel255_all_ones", 32'(bus.s_out), 32'h1F7);

    // Two loads before frame_sync: last one wins.
    cfg[3] = 3; cfg[0] = 1;
    bus.OutSetting = pack_cfg();
    bus.cfg_load = 1'b1;
    step(1);
    cfg[0] = 2;
    bus.OutSetting = pack_cfg();
    step(1);
    bus.cfg_load = 1'b0; bus.frame_sync = 1'b1;
    step(1);
    bus.frame_sync = 1'b0;
    bus.d_in = 9'h004;
    step(2);
    check("last_load_wins", 32'(bus.s_out), 32'h005);

    // Training with all lanes retimed, then reset mid-sequence.
    cfg[0] = 0;
    apply(9'h1FF);
    bus.train_en = 1'b1;
    step(3);
    check("train_k0", 32'(bus.s_out), 32'h1A5);
    step(1);
    check("train_k1", 32'(bus.s_out), 32'h0D2);
    step(2);
    #2;
    rst = 1'b0;
    #1;
    check("midreset_s_out", 32'(bus.s_out), 32'h0);
    check("midreset_busy", 32'(bus.cfg_busy), 32'h0);
    step(1);
    rst = 1'b1;
    bus.train_en = 1'b0; bus.EdgeSel = '0;
    bus.d_in = 9'h0F5;
    step(2);
    check("post_reset_identity", 32'(bus.s_out), 32'h0F5);

    step(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
